// File: rtl/mul_pkg.sv
// Shared multiplier definitions: opcode encodings and pipeline depth.
// Used by the multiplier datapath, the decoder and the hazard unit.
// Holds no logic of its own.
package mul_pkg;

  localparam logic [1:0] MUL_OP_MUL    = 2'b00;
  localparam logic [1:0] MUL_OP_MULH   = 2'b01;
  localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
  localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

  localparam int MUL_LATENCY = 3;

  // rs1 is treated as signed for MULH and MULHSU.
  function automatic logic op_a_signed(input logic [1:0] op);
    return (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
  endfunction

  // rs2 is treated as signed only for MULH.
  function automatic logic op_b_signed(input logic [1:0] op);
    return (op == MUL_OP_MULH);
  endfunction

endpackage

// File: rtl/mul_quad_partial.sv
// Four unsigned HALF x HALF partial products of two 2*HALF-bit magnitudes.
// Latency: combinational, 0 cycles.
// Backpressure: none; the enclosing pipeline stage registers the outputs.
module mul_quad_partial #(
  parameter int HALF = 16
) (
  input  logic [2*HALF-1:0] a_i,
  input  logic [2*HALF-1:0] b_i,
  output logic [2*HALF-1:0] ll_o,
  output logic [2*HALF-1:0] hl_o,
  output logic [2*HALF-1:0] lh_o,
  output logic [2*HALF-1:0] hh_o
);

  logic [2*HALF-1:0] a_lo, a_hi, b_lo, b_hi;

  // Zero-extend each half so the products are computed at full 2*HALF width.
  always_comb begin
    a_lo = {{HALF{1'b0}}, a_i[HALF-1:0]};
    a_hi = {{HALF{1'b0}}, a_i[2*HALF-1:HALF]};
    b_lo = {{HALF{1'b0}}, b_i[HALF-1:0]};
    b_hi = {{HALF{1'b0}}, b_i[2*HALF-1:HALF]};
    ll_o = a_lo * b_lo;
    hl_o = a_hi * b_lo;
    lh_o = a_lo * b_hi;
    hh_o = a_hi * b_hi;
  end

endmodule

// File: rtl/mul_pipe_nbit.sv
// Pipelined RV32M/RV64M multiplier (MUL/MULH/MULHSU/MULHU) with tag passthrough and flush.
// Latency: 3 cycles (S1 sign/magnitude, S2 partial products, S3 sum/negate/select), 1 op/cycle.
// Backpressure: global stall while out_valid & ~out_ready; optional MUL_STALL_CNT_EN adds perf_stall_cnt.
module mul_pipe_nbit #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [TAG_W-1:0] out_tag
`ifdef MUL_STALL_CNT_EN
  ,
  output logic [31:0]      perf_stall_cnt
`endif
);

  import mul_pkg::*;

  localparam int H = WIDTH / 2;

  logic stall;

  // Stage valids
  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;

  // S1: magnitudes, result sign, op, tag
  logic [WIDTH-1:0] mag_a_q, mag_a_d, mag_b_q, mag_b_d;
  logic             neg1_q, neg1_d;
  logic [1:0]       op1_q, op1_d;
  logic [TAG_W-1:0] tag1_q, tag1_d;

  // S2: partial products
  logic [WIDTH-1:0] ll_q, ll_d, hl_q, hl_d, lh_q, lh_d, hh_q, hh_d;
  logic             neg2_q, neg2_d;
  logic [1:0]       op2_q, op2_d;
  logic [TAG_W-1:0] tag2_q, tag2_d;

  // S3: selected result
  logic [WIDTH-1:0] res_q, res_d;
  logic [TAG_W-1:0] tag3_q, tag3_d;

  // Combinational helpers
  logic             sa, sb;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] pp_ll, pp_hl, pp_lh, pp_hh;
  logic [WIDTH:0]   mid;
  logic [2*WIDTH-1:0] p_sum, p_fin;

  assign stall     = v3_q & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = v3_q;
  assign out_res   = res_q;
  assign out_tag   = tag3_q;

  mul_quad_partial #(.HALF(H)) u_quad (
    .a_i  (mag_a_q),
    .b_i  (mag_b_q),
    .ll_o (pp_ll),
    .hl_o (pp_hl),
    .lh_o (pp_lh),
    .hh_o (pp_hh)
  );

  // S1 operand conditioning: strip signs so the partial products stay unsigned.
  always_comb begin
    sa    = in_a[WIDTH-1] & op_a_signed(in_op);
    sb    = in_b[WIDTH-1] & op_b_signed(in_op);
    abs_a = sa ? (~in_a + WIDTH'(1)) : in_a;
    abs_b = sb ? (~in_b + WIDTH'(1)) : in_b;
  end

  // S3 recombination of the partials, sign restore and half select.
  always_comb begin
    mid   = {1'b0, hl_q} + {1'b0, lh_q};
    p_sum = {{WIDTH{1'b0}}, ll_q}
          + ({{(WIDTH-1){1'b0}}, mid} << H)
          + {hh_q, {WIDTH{1'b0}}};
    p_fin = neg2_q ? (~p_sum + (2*WIDTH)'(1)) : p_sum;
  end

  // Next state: whole pipe advances unless stalled; flush kills all valids regardless.
  always_comb begin
    v1_d    = v1_q;    v2_d    = v2_q;    v3_d   = v3_q;
    mag_a_d = mag_a_q; mag_b_d = mag_b_q; neg1_d = neg1_q; op1_d = op1_q; tag1_d = tag1_q;
    ll_d    = ll_q;    hl_d    = hl_q;    lh_d   = lh_q;   hh_d  = hh_q;
    neg2_d  = neg2_q;  op2_d   = op2_q;   tag2_d = tag2_q;
    res_d   = res_q;   tag3_d  = tag3_q;
    if (!stall) begin
      v1_d    = in_valid;
      mag_a_d = abs_a;
      mag_b_d = abs_b;
      neg1_d  = sa ^ sb;
      op1_d   = in_op;
      tag1_d  = in_tag;
      v2_d    = v1_q;
      ll_d    = pp_ll;
      hl_d    = pp_hl;
      lh_d    = pp_lh;
      hh_d    = pp_hh;
      neg2_d  = neg1_q;
      op2_d   = op1_q;
      tag2_d  = tag1_q;
      v3_d    = v2_q;
      res_d   = (op2_q == MUL_OP_MUL) ? p_fin[WIDTH-1:0] : p_fin[2*WIDTH-1:WIDTH];
      tag3_d  = tag2_q;
    end
    if (flush) begin
      v1_d = 1'b0;
      v2_d = 1'b0;
      v3_d = 1'b0;
    end
  end

  // Pipeline registers; reset clears valids and data alike.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0;
      mag_a_q <= '0; mag_b_q <= '0; neg1_q <= 1'b0; op1_q <= '0; tag1_q <= '0;
      ll_q <= '0; hl_q <= '0; lh_q <= '0; hh_q <= '0;
      neg2_q <= 1'b0; op2_q <= '0; tag2_q <= '0;
      res_q <= '0; tag3_q <= '0;
    end else begin
      v1_q <= v1_d; v2_q <= v2_d; v3_q <= v3_d;
      mag_a_q <= mag_a_d; mag_b_q <= mag_b_d; neg1_q <= neg1_d; op1_q <= op1_d; tag1_q <= tag1_d;
      ll_q <= ll_d; hl_q <= hl_d; lh_q <= lh_d; hh_q <= hh_d;
      neg2_q <= neg2_d; op2_q <= op2_d; tag2_q <= tag2_d;
      res_q <= res_d; tag3_q <= tag3_d;
    end
  end

`ifdef MUL_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of stalled cycles; only reset clears it.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mul_pipe_nbit.sv
// Directed bench for mul_pipe_nbit at WIDTH=32: vector table plus stream/stall, flush and reset sequences.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
// Checks perf_stall_cnt when built with MUL_STALL_CNT_EN.
module tb_mul_pipe_nbit;

  localparam int W  = 32;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]    in_op;
  logic [W-1:0]  in_a, in_b, out_res;
  logic [TW-1:0] in_tag, out_tag;
`ifdef MUL_STALL_CNT_EN
  logic [31:0]   perf_stall_cnt;
`endif

  mul_pipe_nbit #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_tag   (out_tag)
`ifdef MUL_STALL_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[14];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, seen, issued, npop, stall_left, stall_seen, rdy_low;
    logic had_stall;
    logic [31:0] prev_res;
    logic [TW-1:0] prev_tag;
    logic [31:0] exp_s[1:6];

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = 2'b00;
    in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;

    //          op     a             b             expected
    vt[0]  = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vt[1]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    vt[2]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000};
    vt[3]  = '{2'b01, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF};
    vt[4]  = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vt[5]  = '{2'b10, 32'h00000002, 32'h80000000, 32'h00000001};
    vt[6]  = '{2'b00, 32'h00000007, 32'h00000006, 32'h0000002A};
    vt[7]  = '{2'b00, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA};
    vt[8]  = '{2'b01, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF};
    vt[9]  = '{2'b11, 32'h00010000, 32'h00010000, 32'h00000001};
    vt[10] = '{2'b01, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF};
    vt[11] = '{2'b01, 32'h80000000, 32'h7FFFFFFF, 32'hC0000000};
    vt[12] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    vt[13] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_res",   64'(out_res),   64'd0);
    chk("reset_out_tag",   64'(out_tag),   64'd0);
    chk("reset_in_ready",  64'(in_ready),  64'd1);
`ifdef MUL_STALL_CNT_EN
    chk("reset_stall_cnt", 64'(perf_stall_cnt), 64'd0);
`endif

    // Table vectors, one at a time, with latency check.
    for (int i = 0; i < 14; i++) begin
      in_valid = 1'b1; in_op = vt[i].op; in_a = vt[i].a; in_b = vt[i].b; in_tag = TW'(i + 1);
      @(negedge clk);
      in_valid = 1'b0;
      k = 1;
      while (!out_valid && k < 10) begin
        @(negedge clk);
        k++;
      end
      chk($sformatf("vec%0d_latency", i), 64'(k), 64'd3);
      chk($sformatf("vec%0d_res", i), 64'(out_res), 64'(vt[i].exp));
      chk($sformatf("vec%0d_tag", i), 64'(out_tag), 64'(i + 1));
    end

    // Stream of 6 MULs, consumer stalls 4 cycles after taking the 2nd result.
    for (int t = 1; t <= 6; t++) exp_s[t] = 32'(t * (t + 10));
    issued = 0; npop = 0; stall_left = 0; stall_seen = 0; rdy_low = 0; had_stall = 1'b0;
    prev_res = '0; prev_tag = '0;
    @(negedge clk);
    for (int cyc = 0; cyc < 60 && npop < 6; cyc++) begin
      out_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      if (issued < 6) begin
        in_valid = 1'b1; in_op = 2'b00;
        in_a = 32'(issued + 1); in_b = 32'(issued + 11); in_tag = TW'(issued + 1);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (had_stall) begin
        chk("stream_hold_res", 64'(out_res), 64'(prev_res));
        chk("stream_hold_tag", 64'(out_tag), 64'(prev_tag));
      end
      if (out_valid && !out_ready) stall_seen++;
      if (!in_ready) rdy_low++;
      had_stall = out_valid && !out_ready;
      prev_res  = out_res;
      prev_tag  = out_tag;
      if (out_valid && out_ready) begin
        npop++;
        chk($sformatf("stream_tag%0d", npop), 64'(out_tag), 64'(npop));
        chk($sformatf("stream_res%0d", npop), 64'(out_res), 64'(exp_s[npop]));
        if (npop == 2) stall_left = 4;
      end
      if (in_valid && in_ready) issued++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream_count", 64'(npop), 64'd6);
    chk("stream_stall_cycles", 64'(stall_seen), 64'd4);
    chk("stream_in_ready_low", 64'(rdy_low), 64'd4);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("stream_no_extra", 64'(seen), 64'd0);

    // Flush with three ops in flight; the op issued right after must survive.
    for (int t = 1; t <= 3; t++) begin
      in_valid = 1'b1; in_op = 2'b11; in_a = 32'(t); in_b = 32'hFFFF0000; in_tag = TW'(t);
      @(negedge clk);
    end
    in_tag = TW'(20); flush = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b1;
    #1;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    in_valid = 1'b1; in_op = 2'b00; in_a = 32'd5; in_b = 32'd9; in_tag = TW'(21);
    @(negedge clk);
    in_valid = 1'b0;
    seen = 0;
    for (int j = 1; j <= 10; j++) begin
      if (out_valid && out_ready) begin
        seen++;
        chk("flush_next_latency", 64'(j), 64'd3);
        chk("flush_next_tag", 64'(out_tag), 64'd21);
        chk("flush_next_res", 64'(out_res), 64'd45);
      end
      @(negedge clk);
    end
    chk("flush_emerged_count", 64'(seen), 64'd1);

    // A request presented together with flush is dropped.
    in_valid = 1'b1; in_op = 2'b00; in_a = 32'd3; in_b = 32'd3; in_tag = TW'(22); flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("flush_drop", 64'(seen), 64'd0);

    // Reset with two ops in flight while the output is stalled.
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 2'b00; in_a = 32'd3; in_b = 32'd4; in_tag = TW'(31);
    @(negedge clk);
    in_a = 32'd5; in_tag = TW'(32);
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    #1;
    chk("rst_pre_stall_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_res",   64'(out_res),   64'd0);
    chk("rst_out_tag",   64'(out_tag),   64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
`ifdef MUL_STALL_CNT_EN
    chk("rst_stall_cnt", 64'(perf_stall_cnt), 64'd0);
`endif
    out_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("rst_no_emerge", 64'(seen), 64'd0);

    // Exactly three stalled cycles on one result.
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 2'b00; in_a = 32'd6; in_b = 32'd7; in_tag = TW'(9);
    @(negedge clk);
    in_valid = 1'b0;
    k = 1;
    while (!out_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("stall3_latency", 64'(k), 64'd3);
    repeat (3) @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("stall3_valid", 64'(out_valid), 64'd1);
    chk("stall3_res", 64'(out_res), 64'd42);
    chk("stall3_tag", 64'(out_tag), 64'd9);
`ifdef MUL_STALL_CNT_EN
    chk("stall3_cnt", 64'(perf_stall_cnt), 64'd3);
`endif
    @(negedge clk);
    chk("stall3_popped", 64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
